// File: rtl/tetris_board_scanner.sv
// Walks the Tetris playfield cell by cell, reads each piece code from board RAM
// and issues one coloured box draw per cell to the box drawer.
module tetris_board_scanner #(
  parameter int COLS       = 10,
  parameter int ROWS       = 20,
  parameter int CELL       = 24,
  parameter int X_ORIGIN   = 200,
  parameter int Y_ORIGIN   = 0,
  parameter int SKIP_EMPTY = 0
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       frame_req,
  output logic [7:0] cell_addr,
  input  logic [2:0] cell_rdata,
  output logic       box_start,
  output logic [9:0] box_x0,
  output logic [8:0] box_y0,
  output logic [8:0] box_color,
  input  logic       box_done,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [9:0]    X_START  = 10'(X_ORIGIN);
  localparam logic [9:0]    X_STEP   = 10'(CELL);
  localparam logic [8:0]    Y_START  = 9'(Y_ORIGIN);
  localparam logic [8:0]    Y_STEP   = 9'(CELL);

  typedef enum logic [2:0] {IDLE, READ, LATCH, ISSUE, WAIT, NEXT, FINISH} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  logic [9:0]    x_acc_reg;
  logic [8:0]    y_acc_reg;
  logic          pending_reg;
  logic [8:0]    color_next;
  logic          start_scan;
  logic          skip_cell;

  assign start_scan = frame_req || pending_reg;
  assign skip_cell  = (SKIP_EMPTY != 0) && (cell_rdata == 3'd0);

  always_comb begin
    color_next = 9'h000;
    case (cell_rdata)
      3'd0: color_next = 9'h000;
      3'd1: color_next = 9'h03F;
      3'd2: color_next = 9'h1F8;
      3'd3: color_next = 9'h145;
      3'd4: color_next = 9'h038;
      3'd5: color_next = 9'h1C0;
      3'd6: color_next = 9'h007;
      3'd7: color_next = 9'h1E0;
      default: color_next = 9'h000;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    box_start  = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start_scan) state_next = READ;
      end
      READ:  state_next = LATCH;
      LATCH: state_next = skip_cell ? NEXT : ISSUE;
      ISSUE: begin
        box_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT: if (box_done) state_next = NEXT;
      NEXT: begin
        if (col_reg < COL_LAST || row_reg < ROW_LAST) state_next = READ;
        else                                           state_next = FINISH;
      end
      FINISH: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      col_reg     <= '0;
      row_reg     <= '0;
      x_acc_reg   <= '0;
      y_acc_reg   <= '0;
      pending_reg <= 1'b0;
      cell_addr   <= 8'd0;
      box_x0      <= 10'd0;
      box_y0      <= 9'd0;
      box_color   <= 9'd0;
    end else begin
      state_reg <= state_next;
      // Requests arriving mid-scan collapse into a single queued redraw.
      if (state_reg == IDLE)  pending_reg <= 1'b0;
      else if (frame_req)     pending_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (start_scan) begin
            col_reg   <= '0;
            row_reg   <= '0;
            x_acc_reg <= X_START;
            y_acc_reg <= Y_START;
            cell_addr <= 8'd0;
          end
        end
        LATCH: begin
          box_color <= color_next;
          box_x0    <= x_acc_reg;
          box_y0    <= y_acc_reg;
        end
        NEXT: begin
          // Row-major order makes the linear address a plain increment.
          if (col_reg < COL_LAST) begin
            col_reg   <= col_reg + 1'b1;
            x_acc_reg <= x_acc_reg + X_STEP;
            cell_addr <= cell_addr + 8'd1;
          end else if (row_reg < ROW_LAST) begin
            col_reg   <= '0;
            row_reg   <= row_reg + 1'b1;
            x_acc_reg <= X_START;
            y_acc_reg <= y_acc_reg + Y_STEP;
            cell_addr <= cell_addr + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tetris_board_scanner.sv
// Randomised bench for tetris_board_scanner: draws are compared against a
// row-major model of the playfield built straight from the cell rules.
module tb_tetris_board_scanner;
  localparam int COLS = 10, ROWS = 20, CELL = 24, XO = 200, YO = 0, NCELL = 200;

  typedef struct {int x; int y; int c; int t;} draw_t;

  logic CLOCK_50 = 1'b0;
  logic resetn = 1'b1;
  logic frame_req = 1'b0, frame_req_s = 1'b0, stray_done = 1'b0, resp_en = 1'b1;
  int   done_delay = 5;

  logic [7:0] cell_addr, cell_addr_s;
  logic [2:0] cell_rdata, cell_rdata_s;
  logic       box_start, box_start_s, box_done, box_done_s;
  logic [9:0] box_x0, box_x0_s;
  logic [8:0] box_y0, box_y0_s, box_color, box_color_s;
  logic       busy, busy_s, frame_done, frame_done_s;

  logic [2:0]  board [256];
  logic [2:0]  board_s [256];
  logic [15:0] sh = '0, sh_s = '0;
  int cyc = 0;
  int n_checks = 0, n_fail = 0, proto_err = 0, fd_s = 0;
  draw_t got[$], got_s[$], exp_q[$];
  int fd_t[$];
  bit outstanding = 0;
  logic [9:0] hx;
  logic [8:0] hy, hc;
  bit [255:0] addr_seen_s;
  int pal[8] = '{'h000, 'h03F, 'h1F8, 'h145, 'h038, 'h1C0, 'h007, 'h1E0};

  tetris_board_scanner dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .frame_req(frame_req),
    .cell_addr(cell_addr), .cell_rdata(cell_rdata), .box_start(box_start),
    .box_x0(box_x0), .box_y0(box_y0), .box_color(box_color), .box_done(box_done),
    .busy(busy), .frame_done(frame_done));

  tetris_board_scanner #(.SKIP_EMPTY(1)) dut_skip (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .frame_req(frame_req_s),
    .cell_addr(cell_addr_s), .cell_rdata(cell_rdata_s), .box_start(box_start_s),
    .box_x0(box_x0_s), .box_y0(box_y0_s), .box_color(box_color_s), .box_done(box_done_s),
    .busy(busy_s), .frame_done(frame_done_s));

  always #10 CLOCK_50 = ~CLOCK_50;

  // Board RAMs with one-cycle read latency and box drawers answering after a fixed delay.
  always @(posedge CLOCK_50) begin
    cyc          <= cyc + 1;
    sh           <= {sh[14:0], box_start};
    sh_s         <= {sh_s[14:0], box_start_s};
    cell_rdata   <= board[cell_addr];
    cell_rdata_s <= board_s[cell_addr_s];
  end
  assign box_done   = (resp_en && sh[done_delay-1]) || stray_done;
  assign box_done_s = sh_s[2];

  always @(negedge CLOCK_50) begin
    draw_t d;
    if (!resetn) outstanding = 0;
    else begin
      if (box_start) begin
        if (outstanding) proto_err++;
        outstanding = 1;
        hx = box_x0; hy = box_y0; hc = box_color;
        d.x = int'(box_x0); d.y = int'(box_y0); d.c = int'(box_color); d.t = cyc;
        got.push_back(d);
      end else if (outstanding) begin
        if (box_x0 !== hx || box_y0 !== hy || box_color !== hc) proto_err++;
        if (box_done) outstanding = 0;
      end
      if (frame_done) fd_t.push_back(cyc);
      if (box_start_s) begin
        d.x = int'(box_x0_s); d.y = int'(box_y0_s); d.c = int'(box_color_s); d.t = cyc;
        got_s.push_back(d);
      end
      if (frame_done_s) fd_s++;
      if (busy_s) addr_seen_s[cell_addr_s] = 1'b1;
    end
  end

  task automatic make_expected(input bit skip_mode);
    draw_t d;
    int code;
    exp_q.delete();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        code = skip_mode ? int'(board_s[r*COLS+c]) : int'(board[r*COLS+c]);
        if (!(skip_mode && code == 0)) begin
          d.x = XO + c*CELL; d.y = YO + r*CELL; d.c = pal[code]; d.t = 0;
          exp_q.push_back(d);
        end
      end
  endtask

  task automatic fill_board(input int mode);
    for (int i = 0; i < 256; i++) board[i] = (mode == 0) ? 3'd0 : 3'($urandom_range(0, 7));
  endtask

  task automatic clear_capture();
    got.delete(); fd_t.delete(); proto_err = 0;
  endtask

  task automatic pulse_req(output int c0);
    @(posedge CLOCK_50); #1;
    frame_req = 1'b1; c0 = cyc;
    @(posedge CLOCK_50); #1;
    frame_req = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit timed_out);
    int k = 0;
    timed_out = 0;
    while (fd_t.size() < n) begin
      @(posedge CLOCK_50); #1;
      k++;
      if (k > budget) begin timed_out = 1; break; end
    end
    repeat (2) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    #5 resetn = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    n_checks++;
    if ({box_start, busy, frame_done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 000", {box_start, busy, frame_done});
    end
    n_checks++;
    if ({box_x0, box_y0, box_color} !== 28'd0) begin
      n_fail++; $display("FAIL reset_box: got %h required 0", {box_x0, box_y0, box_color});
    end
    n_checks++;
    if (cell_addr !== 8'd0) begin
      n_fail++; $display("FAIL reset_addr: got %0d required 0", cell_addr);
    end
    resetn = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #1;
    $display("reset: outputs sampled under reset");
  endtask

  task automatic test_frame(input int mode, input int delay);
    int c0; bit to; int nbad = 0;
    fill_board(mode);
    done_delay = delay;
    clear_capture();
    make_expected(1'b0);
    pulse_req(c0);
    wait_frames(1, 6000, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL frame_timeout: frame_done not seen, required within 6000 cycles"); end
    n_checks++;
    if (got.size() != NCELL) begin n_fail++; $display("FAIL frame_count: got %0d starts required %0d", got.size(), NCELL); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got[i].x !== exp_q[i].x || got[i].y !== exp_q[i].y || got[i].c !== exp_q[i].c) begin
        n_fail++; nbad++;
        if (nbad < 10) $display("FAIL frame_draw[%0d]: got (%0d,%0d,%03h) required (%0d,%0d,%03h)",
                                i, got[i].x, got[i].y, got[i].c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
      end
    end
    n_checks++;
    if (fd_t.size() != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL frame_end: got %0d frame_done busy=%b required 1 and busy=0", fd_t.size(), busy);
    end
    n_checks++;
    if (proto_err != 0) begin n_fail++; $display("FAIL frame_protocol: got %0d hold/handshake errors required 0", proto_err); end
    if (got.size() > 0)
      $display("frame mode=%0d delay=%0d: %0d draws, last at (%0d,%0d)", mode, delay,
               got.size(), got[got.size()-1].x, got[got.size()-1].y);
  endtask

  task automatic test_latency();
    int c0; bit to;
    fill_board(1);
    done_delay = 7;
    clear_capture();
    pulse_req(c0);
    wait_frames(1, 6000, to);
    n_checks++;
    if (to || got.size() < 2) begin
      n_fail++; $display("FAIL latency_run: got %0d starts timeout=%0d required full frame", got.size(), to);
    end else begin
      n_checks++;
      if (got[0].t - c0 != 3) begin n_fail++; $display("FAIL latency_first: got %0d cycles required 3", got[0].t - c0); end
      n_checks++;
      if (got[1].t - c0 != 14 || got[1].x != 224) begin
        n_fail++; $display("FAIL latency_second: got cycle %0d x0=%0d required cycle 14 x0=224", got[1].t - c0, got[1].x);
      end
      n_checks++;
      if (fd_t.size() != 1 || fd_t[0] != got[got.size()-1].t + 9) begin
        n_fail++; $display("FAIL latency_done: got frame_done count %0d required one at last start + 9", fd_t.size());
      end
    end
    $display("latency: first start +%0d, second start +%0d", got.size() > 0 ? got[0].t - c0 : -1,
             got.size() > 1 ? got[1].t - c0 : -1);
  endtask

  task automatic test_stray_done();
    int c0; bit to;
    done_delay = 5;
    clear_capture();
    for (int i = 0; i < 4; i++) begin
      @(posedge CLOCK_50); #1 stray_done = 1'b1;
      @(posedge CLOCK_50); #1 stray_done = 1'b0;
    end
    n_checks++;
    if (got.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stray_idle: got %0d starts busy=%b required 0 starts busy=0", got.size(), busy);
    end
    @(posedge CLOCK_50); #1 frame_req = 1'b1; c0 = cyc;
    @(posedge CLOCK_50); #1 frame_req = 1'b0; stray_done = 1'b1;
    @(posedge CLOCK_50); #1 stray_done = 1'b0;
    wait_frames(1, 6000, to);
    n_checks++;
    if (to || got.size() != NCELL) begin
      n_fail++; $display("FAIL stray_read_count: got %0d starts required %0d", got.size(), NCELL);
    end else begin
      n_checks++;
      if (got[0].t - c0 != 3 || got[1].t - got[0].t != 9 || got[1].x != 224) begin
        n_fail++; $display("FAIL stray_read_timing: got first +%0d gap %0d x1=%0d required +3 gap 9 x1=224",
                           got[0].t - c0, got[1].t - got[0].t, got[1].x);
      end
    end
    $display("stray: %0d draws after stray box_done pulses", got.size());
  endtask

  task automatic test_back_to_back();
    int c0; bit to; int nbad = 0;
    fill_board(1);
    done_delay = 5;
    clear_capture();
    make_expected(1'b0);
    pulse_req(c0);
    for (int p = 0; p < 3; p++) begin
      repeat ($urandom_range(50, 400)) @(posedge CLOCK_50);
      #1 frame_req = 1'b1;
      @(posedge CLOCK_50); #1 frame_req = 1'b0;
    end
    wait_frames(2, 12000, to);
    repeat (20) @(posedge CLOCK_50);
    #1;
    n_checks++;
    if (to || got.size() != 2*NCELL || fd_t.size() != 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d starts %0d frames required %0d starts 2 frames",
                         got.size(), fd_t.size(), 2*NCELL);
    end else begin
      n_checks++;
      if (got[NCELL].t != fd_t[0] + 4) begin
        n_fail++; $display("FAIL b2b_restart: got second frame at %0d required %0d", got[NCELL].t, fd_t[0] + 4);
      end
      for (int i = 0; i < NCELL; i++) begin
        n_checks++;
        if (got[NCELL+i].x !== exp_q[i].x || got[NCELL+i].y !== exp_q[i].y || got[NCELL+i].c !== exp_q[i].c) begin
          n_fail++; nbad++;
          if (nbad < 10) $display("FAIL b2b_draw[%0d]: got (%0d,%0d,%03h) required (%0d,%0d,%03h)", i,
                                  got[NCELL+i].x, got[NCELL+i].y, got[NCELL+i].c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
        end
      end
    end
    n_checks++;
    if (busy !== 1'b0 || proto_err != 0) begin
      n_fail++; $display("FAIL b2b_idle: got busy=%b proto_err=%0d required 0 and 0", busy, proto_err);
    end
    $display("back_to_back: %0d draws, %0d frame_done pulses", got.size(), fd_t.size());
  endtask

  task automatic test_finish_req();
    int c0, c_req, k; bit to;
    fill_board(1);
    done_delay = 5;
    clear_capture();
    pulse_req(c0);
    k = 0;
    while (got.size() < NCELL && k < 6000) begin @(posedge CLOCK_50); #1; k++; end
    n_checks++;
    if (got.size() < NCELL) begin
      n_fail++; $display("FAIL finish_reach: got %0d starts required %0d", got.size(), NCELL);
    end else begin
      while (cyc < got[NCELL-1].t + 7) begin @(posedge CLOCK_50); #1; end
      frame_req = 1'b1; c_req = cyc;
      @(posedge CLOCK_50); #1 frame_req = 1'b0;
      wait_frames(2, 6000, to);
      n_checks++;
      if (to || fd_t.size() != 2 || fd_t[0] != c_req || got.size() != 2*NCELL) begin
        n_fail++; $display("FAIL finish_pending: got %0d frames %0d starts required 2 frames %0d starts, FINISH at %0d",
                           fd_t.size(), got.size(), 2*NCELL, c_req);
      end else begin
        n_checks++;
        if (got[NCELL].t != fd_t[0] + 4) begin
          n_fail++; $display("FAIL finish_restart: got %0d required %0d", got[NCELL].t, fd_t[0] + 4);
        end
      end
    end
    $display("finish_req: %0d draws, %0d frame_done pulses", got.size(), fd_t.size());
  endtask

  task automatic test_reset_midscan();
    int c0, k; bit to; int nbad = 0;
    fill_board(1);
    done_delay = 5;
    clear_capture();
    pulse_req(c0);
    k = 0;
    while (got.size() < 58 && k < 6000) begin @(posedge CLOCK_50); #1; k++; end
    n_checks++;
    if (got.size() != 58) begin
      n_fail++; $display("FAIL midreset_reach: got %0d starts required 58", got.size());
    end
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({cell_addr, box_start, box_x0, box_y0, box_color, busy, frame_done} !== 39'd0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h required 0",
                         {cell_addr, box_start, box_x0, box_y0, box_color, busy, frame_done});
    end
    repeat (3) @(posedge CLOCK_50);
    #1 resetn = 1'b1;
    repeat (20) @(posedge CLOCK_50);
    #1;
    n_checks++;
    if (fd_t.size() != 0 || got.size() != 58 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_quiet: got %0d frame_done %0d starts busy=%b required 0, 58, 0",
                         fd_t.size(), got.size(), busy);
    end
    clear_capture();
    make_expected(1'b0);
    pulse_req(c0);
    wait_frames(1, 6000, to);
    n_checks++;
    if (to || got.size() != NCELL) begin
      n_fail++; $display("FAIL midreset_restart: got %0d starts required %0d", got.size(), NCELL);
    end else begin
      for (int i = 0; i < NCELL; i++) begin
        n_checks++;
        if (got[i].x !== exp_q[i].x || got[i].y !== exp_q[i].y || got[i].c !== exp_q[i].c) begin
          n_fail++; nbad++;
          if (nbad < 10) $display("FAIL midreset_draw[%0d]: got (%0d,%0d,%03h) required (%0d,%0d,%03h)",
                                  i, got[i].x, got[i].y, got[i].c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
        end
      end
    end
    $display("reset_midscan: restart produced %0d draws", got.size());
  endtask

  task automatic test_skip_empty();
    int k, seen, extra, nbad = 0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 256; i++)
        board_s[i] = (pass == 0) ? 3'd0 : (($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0);
      if (pass == 0) board_s[3*COLS+4] = 3'd5;
      make_expected(1'b1);
      got_s.delete(); fd_s = 0; addr_seen_s = '0;
      @(posedge CLOCK_50); #1 frame_req_s = 1'b1;
      @(posedge CLOCK_50); #1 frame_req_s = 1'b0;
      k = 0;
      while (fd_s == 0 && k < 6000) begin @(posedge CLOCK_50); #1; k++; end
      repeat (2) @(posedge CLOCK_50);
      #1;
      n_checks++;
      if (fd_s != 1 || got_s.size() != exp_q.size()) begin
        n_fail++; $display("FAIL skip_count: got %0d starts %0d frames required %0d starts 1 frame",
                           got_s.size(), fd_s, exp_q.size());
      end
      for (int i = 0; i < got_s.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (got_s[i].x !== exp_q[i].x || got_s[i].y !== exp_q[i].y || got_s[i].c !== exp_q[i].c) begin
          n_fail++; nbad++;
          if (nbad < 10) $display("FAIL skip_draw[%0d]: got (%0d,%0d,%03h) required (%0d,%0d,%03h)",
                                  i, got_s[i].x, got_s[i].y, got_s[i].c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
        end
      end
      if (pass == 0) begin
        n_checks++;
        if (got_s.size() != 1 || got_s[0].x != 296 || got_s[0].y != 72 || got_s[0].c != 'h1C0) begin
          n_fail++; $display("FAIL skip_single: got %0d starts required one at (296,72,1C0)", got_s.size());
        end
        seen = 0; extra = 0;
        for (int i = 0; i < 256; i++) begin
          if (addr_seen_s[i] && i < NCELL) seen++;
          if (addr_seen_s[i] && i >= NCELL) extra++;
        end
        n_checks++;
        if (seen != NCELL || extra != 0) begin
          n_fail++; $display("FAIL skip_addr_sweep: got %0d in-range %0d out-of-range required %0d and 0",
                             seen, extra, NCELL);
        end
      end
      $display("skip_empty pass %0d: %0d draws, %0d frame_done", pass, got_s.size(), fd_s);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin board[i] = 3'd0; board_s[i] = 3'd0; end
    test_reset();
    test_frame(0, 5);
    test_frame(1, $urandom_range(1, 8));
    test_frame(1, $urandom_range(1, 8));
    test_latency();
    test_stray_done();
    test_back_to_back();
    test_finish_req();
    test_reset_midscan();
    test_skip_empty();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tetris_board_scanner.md
Name: tetris_board_scanner

Overview:
- Upstream sequencer for the 24x24 cell box drawer.
- On a frame request it walks the Tetris playfield row by row, reading each cell's 3-bit piece code from a synchronous board RAM.
- For each cell it maps the code to a 9-bit RRR_GGG_BBB colour, computes the cell's top-left pixel, and hands one draw request at a time to the box drawer using a start/done handshake.
- It raises frame_done once the whole board has been redrawn.

Parameters:
- COLS, 10, playfield columns.
- ROWS, 20, playfield rows.
- CELL, 24, cell pitch in pixels; must equal the box drawer's box size.
- X_ORIGIN, 200, pixel X of the left edge of column 0.
- Y_ORIGIN, 0, pixel Y of the top edge of row 0.
- SKIP_EMPTY, 0, when 1, cells with code 0 are not drawn.

Ports:
- CLOCK_50  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- frame_req  in  1  request a full-board redraw; sampled every cycle.
- cell_addr  out  8  board RAM read address, equal to row*COLS+col.
- cell_rdata  in  3  board RAM data; valid the cycle after cell_addr is presented.
- box_start  out  1  one-cycle draw request to the box drawer.
- box_x0  out  10  cell top-left X; held stable from box_start until box_done.
- box_y0  out  9  cell top-left Y; held stable likewise.
- box_color  out  9  cell colour, RRR_GGG_BBB; held stable likewise.
- box_done  in  1  one-cycle completion pulse from the box drawer.
- busy  out  1  high while a frame scan is in progress.
- frame_done  out  1  one-cycle pulse after the last cell is handled.

Behaviour:
- Reset state: FSM in IDLE, row=col=0, pending=0, cell_addr=0.
- Output reset values: box_start=0, box_x0=0, box_y0=0, box_color=0, busy=0, frame_done=0.
- FSM states: IDLE, READ, LATCH, ISSUE, WAIT, NEXT, FINISH.
- IDLE:
  - If frame_req or pending is set, clear pending, set row=col=0 and x_acc=X_ORIGIN, y_acc=Y_ORIGIN, then go to READ.
- READ:
  - cell_addr = row*COLS+col, maintained as a running counter (no multiplier).
  - Next state is LATCH.
- LATCH:
  - Register box_color from palette(cell_rdata), box_x0 from x_acc, box_y0 from y_acc.
  - If SKIP_EMPTY=1 and cell_rdata=0, go to NEXT; otherwise go to ISSUE.
- ISSUE: box_start=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - Hold all box_* outputs.
  - On box_done go to NEXT. box_done seen in any other state is ignored.
- NEXT:
  - If col<COLS-1: col+1, x_acc+=CELL, go to READ.
  - Else if row<ROWS-1: col=0, row+1, x_acc=X_ORIGIN, y_acc+=CELL, go to READ.
  - Else go to FINISH.
- FINISH: frame_done=1 for one cycle, then go to IDLE.
- busy=1 in every state except IDLE. frame_done=1 only in FINISH.
- Palette (code→colour):
  - 0→000 (black), 1→03F (cyan), 2→1F8 (yellow), 3→145 (purple).
  - 4→038 (green), 5→1C0 (red), 6→007 (blue), 7→1E0 (orange).
- Latency:
  - frame_req sampled in IDLE at cycle 0 produces the first box_start at cycle 3.
  - box_done sampled at cycle t produces the next box_start at t+4.
- Arithmetic:
  - x_acc is 10-bit and y_acc is 9-bit, unsigned.
  - Defaults give a maximum x0 of 416 and y0 of 456, so the drawn area stays inside 640x480.
  - Overflow is not checked; parameter choice is the integrator's responsibility.
- frame_req while busy:
  - Sets pending; multiple requests collapse into one.
  - The pending request starts a new scan on the cycle after FINISH→IDLE.
  - frame_req in IDLE starts immediately and does not set pending.
- A frame_req coinciding with FINISH sets pending.
- Reset asserted mid-scan: return immediately to the reset state, with no frame_done pulse and pending cleared.
- box_start is never reasserted before box_done for the previous request.

Test Plan:
- Defaults, all cells code 0, SKIP_EMPTY=0, box_done returned 5 cycles after each start → exactly 200 box_start pulses, first at (200,0) colour 000, last at (416,456), followed by one frame_done pulse; busy low afterwards.
- Cell (row 3, col 4) = code 5, others 0, SKIP_EMPTY=1 → exactly one box_start with x0=296, y0=72, color=1C0, cell_addr sweeps 0..199, frame_done fires once.
- Latency: frame_req at cycle 0 → box_start at cycle 3; box_done at cycle 10 → next box_start at cycle 14 with x0=224.
- Three frame_req pulses mid-scan → exactly two complete frames (400 starts), second frame beginning the cycle after the first frame's FINISH→IDLE.
- resetn pulled low while in WAIT at cell 57 → all outputs zero immediately, no frame_done; a new frame_req restarts from cell 0.
- Stray box_done in IDLE or READ → ignored: no advance, no extra box_start.
